line_mem_responder: RTL and testbench

//  Memory-side responder for the cache <-> slow-memory line interface (mem_read/mem_write/mem_addr[31:4]/
//  mem_wdata/mem_rdata/mem_ready). Serves 128-bit line reads and writes from an internal line array with
//  a fixed, programmable latency. One instance sits behind D_cache and one behind I_cache for

---
 rtl/line_mem_responder_if.sv | 37 +++
 rtl/line_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_line_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_responder_if.sv
// Line interface between a cache (master) and its slow-memory responder (slave).
// The cache raises mem_read or mem_write with a line address and holds the request
// until it sees the single-cycle mem_ready pulse. proto_err reports requester misuse.
interface line_mem_responder_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              proto_err;

    // Cache side: issues requests, consumes completion and read data.
    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready,
        input  proto_err
    );

    // Memory side: accepts requests, returns completion and read data.
    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready,
        output proto_err
    );
endinterface

// File: rtl/line_mem_responder.sv
// Memory-side responder for the cache line interface. Holds 2**IDX_W lines of
// DATA_W bits and answers one request at a time with a fixed latency.
// Transaction shape: IDLE (accept) -> WAIT (count down) -> RESP -> GAP -> IDLE.
// RESP is the cycle in which the registered response is prepared; mem_ready and
// mem_rdata are therefore visible during the cycle that starts LATENCY edges
// after the accepting edge. A write is committed on the edge that leaves RESP.
// The GAP cycle ignores requests so a cache that drops its request one cycle
// after seeing mem_ready is never served twice.
// Reset returns the control path to IDLE but never clears the line array.
module line_mem_responder #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128,
    parameter int IDX_W   = 8,
    parameter int LATENCY = 4      // legal range 2..15
) (
    input  logic                 clk,
    input  logic                 proc_reset,
    line_mem_responder_if.slave  bus
);

    localparam int LINES = 1 << IDX_W;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        WAIT_S = 2'd1,
        RESP_S = 2'd2,
        GAP_S  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;

    // Values captured at acceptance; the transaction in flight uses only these.
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  wdata_r;
    logic               kind_wr_r;
    logic [IDX_W-1:0]   idx_s;

    logic               req_s;
    logic               both_s;
    logic               accept_s;
    logic               in_flight_s;
    logic               pair_viol_s;
    logic               hold_viol_s;
    logic               commit_s;

    logic               mem_ready_r;
    logic [DATA_W-1:0]  mem_rdata_r;
    logic               proto_err_r;

    logic [DATA_W-1:0]  line_r [0:LINES-1];

    assign req_s       = bus.mem_read | bus.mem_write;
    assign both_s      = bus.mem_read & bus.mem_write;
    assign in_flight_s = (state_r == WAIT_S) || (state_r == RESP_S);

    // Upper address bits alias onto the same line.
    assign idx_s = addr_r[IDX_W-1:0];

    // Read and write together is illegal everywhere except the dead GAP cycle.
    assign pair_viol_s = both_s & (state_r != GAP_S);

    // While a transaction is in flight the request must stay exactly as accepted.
    assign hold_viol_s = in_flight_s &
                         (~req_s | (bus.mem_write != kind_wr_r) | (bus.mem_addr != addr_r));

    // Writes land on the edge leaving RESP unless that edge is a reset.
    assign commit_s = (state_r == RESP_S) & kind_wr_r & ~proc_reset;

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_r <= IDLE_S;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, then RESP and GAP.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE_S: begin
                if (req_s) begin
                    accept_s     = 1'b1;
                    cnt_next_s   = CNT_LOAD;
                    state_next_s = WAIT_S;
                end else begin
                    state_next_s = IDLE_S;
                end
            end
            WAIT_S: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = RESP_S;
                end else begin
                    cnt_next_s   = cnt_r - CNT_ONE;
                    state_next_s = WAIT_S;
                end
            end
            RESP_S: begin
                state_next_s = GAP_S;
            end
            GAP_S: begin
                state_next_s = IDLE_S;
            end
            default: begin
                state_next_s = IDLE_S;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // Capture address, write data and kind at acceptance; write wins a tie.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            kind_wr_r <= 1'b0;
        end else if (accept_s) begin
            addr_r    <= bus.mem_addr;
            wdata_r   <= bus.mem_wdata;
            kind_wr_r <= bus.mem_write;
        end
    end

    // Line array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            line_r[idx_s] <= wdata_r;
        end
    end

    // Registered response: ready pulse and read data, data forced to zero otherwise.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            mem_ready_r <= 1'b0;
            mem_rdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_ready_r <= (state_r == RESP_S);
            if ((state_r == RESP_S) && !kind_wr_r) begin
                mem_rdata_r <= line_r[idx_s];
            end else begin
                mem_rdata_r <= {DATA_W{1'b0}};
            end
        end
    end

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            proto_err_r <= 1'b0;
        end else begin
            proto_err_r <= proto_err_r | pair_viol_s | hold_viol_s;
        end
    end

    assign bus.mem_ready = mem_ready_r;
    assign bus.mem_rdata = mem_rdata_r;
    assign bus.proto_err = proto_err_r;

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: directed scenarios plus randomized transactions,
// checked every cycle against a transaction-level model kept in cycle numbers.
module tb_line_mem_responder;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_mem_responder_if #(.ADDR_W(28), .DATA_W(128)) ifm ();
    line_mem_responder_if #(.ADDR_W(28), .DATA_W(128)) if2 ();
    line_mem_responder_if #(.ADDR_W(28), .DATA_W(128)) if15 ();

    line_mem_responder #(.ADDR_W(28), .DATA_W(128), .IDX_W(8), .LATENCY(LAT))
        u_dut (.clk(clk), .proc_reset(rst), .bus(ifm));
    line_mem_responder #(.ADDR_W(28), .DATA_W(128), .IDX_W(8), .LATENCY(2))
        u_l2 (.clk(clk), .proc_reset(rst), .bus(if2));
    line_mem_responder #(.ADDR_W(28), .DATA_W(128), .IDX_W(8), .LATENCY(15))
        u_l15 (.clk(clk), .proc_reset(rst), .bus(if15));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (cycle-number arithmetic) ----------------
    int           cyc = 0;
    bit           busy = 1'b0;
    int           acc = 0;          // edge number at which the request was accepted
    logic [27:0]  lat_addr;
    bit           lat_kind;         // 1 = write
    logic [127:0] lat_data;
    logic [127:0] mdl_mem [256];
    bit           known [256];
    bit           exp_ready = 1'b0;
    logic [127:0] exp_rdata = '0;
    bit           exp_rd_known = 1'b1;
    bit           exp_err = 1'b0;
    bit           cmp_en = 1'b0;

    task automatic model_step();
        bit req, viol, in_gap, in_flight;
        logic [7:0] li;
        cyc++;
        exp_ready = 1'b0;
        exp_rdata = '0;
        exp_rd_known = 1'b1;
        if (rst) begin
            busy = 1'b0;
            exp_err = 1'b0;
            return;
        end
        req = ifm.mem_read | ifm.mem_write;
        in_gap = busy && (cyc == acc + LAT + 1);
        in_flight = busy && (cyc >= acc + 1) && (cyc <= acc + LAT);
        viol = 1'b0;
        if (ifm.mem_read && ifm.mem_write && !in_gap) viol = 1'b1;
        if (in_flight && (!req || (ifm.mem_write != lat_kind) || (ifm.mem_addr != lat_addr))) viol = 1'b1;
        li = lat_addr[7:0];
        if (busy && cyc == acc + LAT) begin
            exp_ready = 1'b1;
            if (lat_kind) begin
                mdl_mem[li] = lat_data;
                known[li] = 1'b1;
            end else begin
                exp_rdata = mdl_mem[li];
                exp_rd_known = known[li];
            end
        end
        if (busy && cyc >= acc + LAT + 2) busy = 1'b0;
        if (!busy && req) begin
            busy = 1'b1;
            acc = cyc;
            lat_addr = ifm.mem_addr;
            lat_kind = ifm.mem_write;
            lat_data = ifm.mem_wdata;
        end
        exp_err = exp_err | viol;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of the main DUT against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("cyc_ready", {127'd0, ifm.mem_ready}, {127'd0, exp_ready});
            if (exp_rd_known) check("cyc_rdata", ifm.mem_rdata, exp_rdata);
            check("cyc_proto_err", {127'd0, ifm.proto_err}, {127'd0, exp_err});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        ifm.mem_read = 1'b0;
        ifm.mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One transaction held until mem_ready; optional read+write pair and address change.
    task automatic do_txn(input bit wr, input bit both, input logic [27:0] a, input logic [127:0] d,
                          input bit chg, input logic [27:0] a2,
                          output int lat, output logic [127:0] rd);
        int n;
        bit seen;
        @(posedge clk); #1;
        ifm.mem_write = wr | both;
        ifm.mem_read = ~wr | both;
        ifm.mem_addr = a;
        ifm.mem_wdata = d;
        n = 0;
        seen = 1'b0;
        rd = '0;
        lat = -1;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            if (chg && n == 2) begin
                #1;
                ifm.mem_addr = a2;
            end
            @(negedge clk);
            if (ifm.mem_ready) begin
                seen = 1'b1;
                lat = n - 1;
                rd = ifm.mem_rdata;
            end
        end
        @(posedge clk); #1;
        ifm.mem_read = 1'b0;
        ifm.mem_write = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: got no mem_ready expected mem_ready within 40 cycles");
        end
    endtask

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_X  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] PAT_D  = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    initial begin
        int lat, n, pulses, cnt;
        int pe [3];
        int f2, f15, w2, w15;
        logic [127:0] rd;
        bit wr;
        logic [7:0] ri;
        logic [31:0] up;

        ifm.mem_read = 1'b0;  ifm.mem_write = 1'b0;  ifm.mem_addr = '0;  ifm.mem_wdata = '0;
        if2.mem_read = 1'b0;  if2.mem_write = 1'b0;  if2.mem_addr = '0;  if2.mem_wdata = '0;
        if15.mem_read = 1'b0; if15.mem_write = 1'b0; if15.mem_addr = '0; if15.mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_ready", {127'd0, ifm.mem_ready}, 128'd0);
        check("reset_rdata", ifm.mem_rdata, 128'd0);
        check("reset_proto_err", {127'd0, ifm.proto_err}, 128'd0);

        // 1: write then read
        do_txn(1'b1, 1'b0, 28'h005, PAT_A5, 1'b0, 28'h0, lat, rd);
        check("t1_write_latency", lat, 4);
        do_txn(1'b0, 1'b0, 28'h005, '0, 1'b0, 28'h0, lat, rd);
        check("t1_read_latency", lat, 4);
        check("t1_read_data", rd, PAT_A5);

        // 3: alias 0x003 / 0x103
        do_txn(1'b1, 1'b0, 28'h003, PAT_X, 1'b0, 28'h0, lat, rd);
        do_txn(1'b0, 1'b0, 28'h103, '0, 1'b0, 28'h0, lat, rd);
        check("t3_alias_data", rd, PAT_X);
        check("t3_no_proto_err", {127'd0, ifm.proto_err}, 128'd0);

        // 4: request held across three reads
        @(posedge clk); #1;
        ifm.mem_read = 1'b1;
        ifm.mem_addr = 28'h005;
        n = 0;
        pulses = 0;
        while (pulses < 3 && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ifm.mem_ready) begin
                pe[pulses] = n;
                pulses++;
            end
        end
        @(posedge clk); #1;
        ifm.mem_read = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifm.mem_ready) cnt++;
        end
        check("t4_pulse_count", pulses, 3);
        check("t4_first_latency", pe[0] - 1, 4);
        check("t4_spacing_1", pe[1] - pe[0], LAT + 2);
        check("t4_spacing_2", pe[2] - pe[1], LAT + 2);
        check("t4_no_extra_pulse", cnt, 0);

        // 5a: read and write together -> write performed, flag set
        do_txn(1'b1, 1'b1, 28'h007, PAT_D, 1'b0, 28'h0, lat, rd);
        check("t5_pair_latency", lat, 4);
        check("t5_pair_proto_err", {127'd0, ifm.proto_err}, 128'd1);
        do_txn(1'b0, 1'b0, 28'h007, '0, 1'b0, 28'h0, lat, rd);
        check("t5_pair_write_done", rd, PAT_D);
        check("t5_err_sticky", {127'd0, ifm.proto_err}, 128'd1);
        do_reset();
        @(negedge clk);
        check("t5_err_cleared", {127'd0, ifm.proto_err}, 128'd0);

        // 5b: address changed during WAIT -> data from latched address
        do_txn(1'b0, 1'b0, 28'h005, '0, 1'b1, 28'h003, lat, rd);
        check("t5_chg_data", rd, PAT_A5);
        check("t5_chg_proto_err", {127'd0, ifm.proto_err}, 128'd1);
        do_reset();

        // 6: reset in WAIT aborts the write
        @(posedge clk); #1;
        ifm.mem_write = 1'b1;
        ifm.mem_addr = 28'h005;
        ifm.mem_wdata = PAT_X;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        ifm.mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifm.mem_ready) cnt++;
        end
        check("t6_no_ready", cnt, 0);
        do_txn(1'b0, 1'b0, 28'h005, '0, 1'b0, 28'h0, lat, rd);
        check("t6_old_data", rd, PAT_A5);

        // Randomized legal traffic
        for (int t = 0; t < 60; t++) begin
            wr = 1'($urandom_range(0, 1));
            ri = 8'($urandom_range(0, 15));
            up = $urandom;
            do_txn(wr, 1'b0, {up[19:0], ri}, {$urandom, $urandom, $urandom, $urandom},
                   1'b0, 28'h0, lat, rd);
            check("rand_latency", lat, LAT);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        check("rand_no_proto_err", {127'd0, ifm.proto_err}, 128'd0);

        // 2: latency sweep on LATENCY=2 and LATENCY=15 instances
        @(posedge clk); #1;
        if2.mem_read = 1'b1;
        if15.mem_read = 1'b1;
        n = 0; f2 = -1; f15 = -1; w2 = 0; w15 = 0;
        while (n < 30) begin
            @(posedge clk); #1;
            if (f2 >= 0) if2.mem_read = 1'b0;
            if (f15 >= 0) if15.mem_read = 1'b0;
            n++;
            @(negedge clk);
            if (if2.mem_ready) begin
                w2++;
                if (f2 < 0) f2 = n;
            end
            if (if15.mem_ready) begin
                w15++;
                if (f15 < 0) f15 = n;
            end
        end
        check("t2_lat2_first", f2 - 1, 2);
        check("t2_lat2_width", w2, 1);
        check("t2_lat15_first", f15 - 1, 15);
        check("t2_lat15_width", w15, 1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
